brp_update_sched: RTL and testbench
===================================

# brp_update_sched

Update scheduler for the bimodal branch predictor's pattern history table (PHT). It accepts resolved conditional branches from EX and generates a registered redirect on every misprediction. It queues the saturating-counter updates and serialises them onto the PHT's single shared read/write port, giving IF-stage prediction reads priority. It also initialises the PHT after reset and keeps the prediction-accuracy counters.

## Interface
Parameters:
- PHT_IDX_W, 6 — PHT index width (2^PHT_IDX_W two-bit entries)
- FIFO_DEPTH, 4 — update queue depth (power of two, ≥2)
- CNT_W, 32 — accuracy counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  resolved conditional branch present in EX
- ex_pc  in  32  PC of that branch
- ex_target  in  32  computed taken target
- ex_taken  in  1  actual outcome
- ex_predicted  in  1  prediction carried down the pipeline
- ex_ctr  in  2  PHT counter value read at prediction time
- if_rd_req  in  1  IF needs the PHT port this cycle (branch opcode in IF)
- stall_ex  out  1  queue full; EX must hold and keep ex_valid
- pht_rd_block  out  1  IF read denied this cycle; IF must stall
- pht_we  out  1  PHT write enable
- pht_waddr  out  PHT_IDX_W  PHT write index
- pht_wdata  out  2  PHT write data
- ready  out  1  PHT initialised; while low, IF must predict not-taken
- redirect  out  1  one-cycle misprediction pulse
- redirect_pc  out  32  correct fetch PC
- c_total  out  CNT_W  resolved branches
- c_correct  out  CNT_W  correctly predicted branches

## Operation
- FSM states: INIT, RUN. Reset enters INIT with init_idx = 0.
- INIT behaviour:
  - pht_we = 1 every cycle, pht_waddr = init_idx, pht_wdata = 2'b01 (weakly not-taken).
  - init_idx increments each cycle.
  - The cycle that writes index 2^PHT_IDX_W−1 transitions to RUN.
  - No enqueues occur in INIT; redirects and counters still operate.
- Accepting a branch:
  - accept = ex_valid && !stall_ex.
  - Mispredict = accept && (ex_taken != ex_predicted).
- Counter update:
  - new_ctr = ex_taken ? (ex_ctr==3 ? 3 : ex_ctr+1) : (ex_ctr==0 ? 0 : ex_ctr−1).
  - The update {idx = ex_pc[PHT_IDX_W+1:2], new_ctr} is enqueued on accept in RUN only if new_ctr != ex_ctr. Unchanged counters are dropped.
- Write arbitration in RUN:
  - Grant write = !empty && (!if_rd_req || full).
  - On grant: pht_we = 1, pht_waddr and pht_wdata come from the queue head, and the head pops.
  - pht_rd_block = full && if_rd_req. When full, the write wins to guarantee forward progress.
- Queue rules:
  - stall_ex = full, taken from the registered count; there is no same-cycle pop bypass.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Duplicate indices in the queue are written in order, last writer wins. Lost updates caused by a stale ex_ctr are an accepted approximation.
- Redirect: registered. redirect_pc = ex_taken ? ex_target : ex_pc + 4, with 32-bit wrap.
- Counters: c_total += 1 on accept; c_correct += 1 on accept && !mispredict. Both wrap at 2^CNT_W.

## Timing
- Reset values (cycle after rst high):
  - state = INIT, queue empty, stall_ex = 0, ready = 0.
  - redirect = 0, redirect_pc = 0, c_total = 0, c_correct = 0.
  - pht_we = 1, pht_waddr = 0. pht_we, pht_waddr and pht_wdata are combinational from state, queue and if_rd_req.
- INIT length: exactly 2^PHT_IDX_W cycles after rst deasserts. ready rises in the first RUN cycle.
- Redirect latency: accept at edge N → redirect = 1 in cycle N+1 for exactly one cycle. Back-to-back mispredicts give back-to-back pulses.
- Write latency: an entry pushed at edge N can be written in cycle N+1 at the earliest.
- Full queue: stall_ex lasts at most one cycle per full event, because a full queue always pops.
- rst asserted mid-operation: the queue is flushed (pending updates discarded), any pending redirect is cancelled, and the FSM restarts INIT from index 0.

## Test plan
- Reset with PHT_IDX_W=6 → 64 consecutive writes of 2'b01 to indices 0..63; ready = 1 on cycle 65; c_total = c_correct = 0.
- In RUN: ex_valid, ex_pc=0x100, ex_taken=1, ex_predicted=0, ex_ctr=1, ex_target=0x140, if_rd_req=0 → next cycle redirect=1, redirect_pc=0x140, pht_we=1, pht_waddr=0, pht_wdata=2; c_total=1, c_correct=0.
- ex_taken=1, ex_predicted=1, ex_ctr=3 → no enqueue, no redirect, c_total and c_correct both +1.
- Hold if_rd_req=1 and push 4 updates → no writes until full; then stall_ex=1, pht_rd_block=1, one pop per cycle; entries drain in push order.
- ex_taken=0, ex_predicted=1, ex_pc=0xFFFFFFFC → redirect_pc=0x00000000.
- Assert rst with 3 entries queued and a redirect pending → queue empty, redirect=0, INIT restarts at index 0.

Source files
------------

// File: rtl/brp_update_sched.sv
// Update scheduler for the bimodal branch predictor PHT: misprediction redirect,
// queued 2-bit counter updates on the shared PHT port, PHT initialisation, accuracy counters.
module brp_update_sched #(
    parameter int PHT_IDX_W  = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_target,
    input  logic                 ex_taken,
    input  logic                 ex_predicted,
    input  logic [1:0]           ex_ctr,
    input  logic                 if_rd_req,
    output logic                 stall_ex,
    output logic                 pht_rd_block,
    output logic                 pht_we,
    output logic [PHT_IDX_W-1:0] pht_waddr,
    output logic [1:0]           pht_wdata,
    output logic                 ready,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic [CNT_W-1:0]     c_total,
    output logic [CNT_W-1:0]     c_correct
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int QCNT_W = PTR_W + 1;
    localparam logic [PHT_IDX_W-1:0] LAST_IDX = {PHT_IDX_W{1'b1}};
    localparam logic [QCNT_W-1:0]    Q_FULL   = QCNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] f_next_ctr(input logic taken, input logic [1:0] ctr);
        logic [1:0] v;
        if (taken) begin
            v = (ctr == 2'd3) ? 2'd3 : (ctr + 2'd1);
        end else begin
            v = (ctr == 2'd0) ? 2'd0 : (ctr - 2'd1);
        end
        return v;
    endfunction

    state_t               r_state;
    logic [PHT_IDX_W-1:0] r_init_idx;
    logic                 r_ready;

    logic [PHT_IDX_W-1:0] r_q_idx [FIFO_DEPTH];
    logic [1:0]           r_q_ctr [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [QCNT_W-1:0]    r_count;

    logic                 r_redirect;
    logic [31:0]          r_redirect_pc;
    logic [CNT_W-1:0]     r_total;
    logic [CNT_W-1:0]     r_correct;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_mispredict;
    logic [1:0]           w_new_ctr;
    logic [PHT_IDX_W-1:0] w_idx;
    logic                 w_push;
    logic                 w_pop;

    // Full/empty come only from the registered count, so a pop never frees a slot the same cycle.
    assign w_full       = (r_count == Q_FULL);
    assign w_empty      = (r_count == {QCNT_W{1'b0}});
    assign w_accept     = ex_valid && !w_full;
    assign w_mispredict = w_accept && (ex_taken != ex_predicted);
    assign w_new_ctr    = f_next_ctr(ex_taken, ex_ctr);
    assign w_idx        = ex_pc[PHT_IDX_W+1:2];
    assign w_push       = w_accept && (r_state == ST_RUN) && (w_new_ctr != ex_ctr);
    assign w_pop        = (r_state == ST_RUN) && !w_empty && (!if_rd_req || w_full);

    // Init/run sequencer: sweeps every PHT entry once after reset, then raises ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_idx <= {PHT_IDX_W{1'b0}};
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_idx <= r_init_idx + PHT_IDX_W'(1);
                    if (r_init_idx == LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_init_idx <= {PHT_IDX_W{1'b0}};
                    r_ready    <= 1'b0;
                end
            endcase
        end
    end

    // Update queue storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr] <= w_idx;
            r_q_ctr[r_wr_ptr] <= w_new_ctr;
        end
    end

    // Update queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {QCNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + QCNT_W'(1);
                2'b01:   r_count <= r_count - QCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Redirect pulse and accuracy counters; both run in INIT as well as RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'h0000_0000;
            r_total       <= {CNT_W{1'b0}};
            r_correct     <= {CNT_W{1'b0}};
        end else begin
            r_redirect <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= ex_taken ? ex_target : (ex_pc + 32'd4);
            end
            if (w_accept) begin
                r_total <= r_total + CNT_W'(1);
                if (!w_mispredict) begin
                    r_correct <= r_correct + CNT_W'(1);
                end
            end
        end
    end

    // Shared PHT write port: init sweep, else queue head when the arbiter grants it.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = {PHT_IDX_W{1'b0}};
        pht_wdata = 2'b00;
        if (r_state == ST_INIT) begin
            pht_we    = 1'b1;
            pht_waddr = r_init_idx;
            pht_wdata = 2'b01;
        end else if (w_pop) begin
            pht_we    = 1'b1;
            pht_waddr = r_q_idx[r_rd_ptr];
            pht_wdata = r_q_ctr[r_rd_ptr];
        end else begin
            pht_we    = 1'b0;
        end
    end

    assign stall_ex     = w_full;
    assign pht_rd_block = w_full && if_rd_req;
    assign ready        = r_ready;
    assign redirect     = r_redirect;
    assign redirect_pc  = r_redirect_pc;
    assign c_total      = r_total;
    assign c_correct    = r_correct;

endmodule

// File: tb/tb_brp_update_sched.sv
// Directed self-checking bench for brp_update_sched: inputs change on the falling
// edge, outputs are sampled 1 ns later, expected values are hand-computed.
module tb_brp_update_sched;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_predicted;
    logic [1:0]  ex_ctr;
    logic        if_rd_req;
    logic        stall_ex;
    logic        pht_rd_block;
    logic        pht_we;
    logic [5:0]  pht_waddr;
    logic [1:0]  pht_wdata;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] c_total;
    logic [31:0] c_correct;

    int n_checks;
    int n_errors;
    int init_bad;

    brp_update_sched #(.PHT_IDX_W(6), .FIFO_DEPTH(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_target    (ex_target),
        .ex_taken     (ex_taken),
        .ex_predicted (ex_predicted),
        .ex_ctr       (ex_ctr),
        .if_rd_req    (if_rd_req),
        .stall_ex     (stall_ex),
        .pht_rd_block (pht_rd_block),
        .pht_we       (pht_we),
        .pht_waddr    (pht_waddr),
        .pht_wdata    (pht_wdata),
        .ready        (ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .c_total      (c_total),
        .c_correct    (c_correct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic pr, input logic [1:0] ctr);
        ex_valid     = v;
        ex_pc        = pc;
        ex_target    = tgt;
        ex_taken     = tk;
        ex_predicted = pr;
        ex_ctr       = ctr;
    endtask

    task automatic next;
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        init_bad  = 0;
        rst       = 1'b1;
        if_rd_req = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);

        // reset state
        repeat (2) @(posedge clk);
        next(); #1;
        chk("rst_stall", {31'd0, stall_ex}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_c_total", c_total, 32'd0);
        chk("rst_c_correct", c_correct, 32'd0);
        chk("rst_pht_we", {31'd0, pht_we}, 32'd1);
        chk("rst_pht_waddr", {26'd0, pht_waddr}, 32'd0);
        rst = 1'b0;

        // INIT sweep: 64 writes of 01 to indices 0..63, ready low throughout
        for (int i = 0; i < 64; i++) begin
            if (pht_we !== 1'b1 || pht_waddr !== 6'(i) || pht_wdata !== 2'b01 || ready !== 1'b0)
                init_bad = init_bad + 1;
            next(); #1;
        end
        chk("init_sweep_bad_cycles", init_bad, 32'd0);
        chk("run_ready", {31'd0, ready}, 32'd1);
        chk("run_idle_we", {31'd0, pht_we}, 32'd0);
        chk("run_c_total0", c_total, 32'd0);

        // mispredict taken: idx 0, ctr 1 -> 2, target 0x140
        set_ex(1'b1, 32'h0000_0100, 32'h0000_0140, 1'b1, 1'b0, 2'd1);
        next(); set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0); #1;
        chk("mp_redirect", {31'd0, redirect}, 32'd1);
        chk("mp_redirect_pc", redirect_pc, 32'h0000_0140);
        chk("mp_we", {31'd0, pht_we}, 32'd1);
        chk("mp_waddr", {26'd0, pht_waddr}, 32'd0);
        chk("mp_wdata", {30'd0, pht_wdata}, 32'd2);
        chk("mp_c_total", c_total, 32'd1);
        chk("mp_c_correct", c_correct, 32'd0);

        // correct prediction with saturated counter: no enqueue, no redirect
        next(); set_ex(1'b1, 32'h0000_0180, 32'h0000_0200, 1'b1, 1'b1, 2'd3); #1;
        chk("pulse_one_cycle", {31'd0, redirect}, 32'd0);
        chk("popped_we", {31'd0, pht_we}, 32'd0);
        next(); set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0); #1;
        chk("sat_redirect", {31'd0, redirect}, 32'd0);
        chk("sat_no_write", {31'd0, pht_we}, 32'd0);
        chk("sat_c_total", c_total, 32'd2);
        chk("sat_c_correct", c_correct, 32'd1);

        // IF holds the port: fill queue with idx1..4, no writes until full
        if_rd_req = 1'b1;
        set_ex(1'b1, 32'h0000_0104, 32'h0, 1'b0, 1'b0, 2'd3); #1;
        chk("fill1_we", {31'd0, pht_we}, 32'd0);
        next(); set_ex(1'b1, 32'h0000_0108, 32'h0, 1'b1, 1'b1, 2'd1); #1;
        chk("fill2_we", {31'd0, pht_we}, 32'd0);
        next(); set_ex(1'b1, 32'h0000_010C, 32'h0, 1'b1, 1'b1, 2'd2); #1;
        chk("fill3_we", {31'd0, pht_we}, 32'd0);
        next(); set_ex(1'b1, 32'h0000_0110, 32'h0, 1'b0, 1'b0, 2'd1); #1;
        chk("fill4_we", {31'd0, pht_we}, 32'd0);
        chk("fill4_stall", {31'd0, stall_ex}, 32'd0);
        next(); set_ex(1'b1, 32'h0000_0114, 32'h0, 1'b1, 1'b1, 2'd0); #1;
        chk("full_stall", {31'd0, stall_ex}, 32'd1);
        chk("full_rd_block", {31'd0, pht_rd_block}, 32'd1);
        chk("full_we", {31'd0, pht_we}, 32'd1);
        chk("full_waddr", {26'd0, pht_waddr}, 32'd1);
        chk("full_wdata", {30'd0, pht_wdata}, 32'd2);
        next(); if_rd_req = 1'b0; #1;
        chk("after_full_stall", {31'd0, stall_ex}, 32'd0);
        chk("after_full_block", {31'd0, pht_rd_block}, 32'd0);
        chk("drain2_waddr", {26'd0, pht_waddr}, 32'd2);
        chk("drain2_wdata", {30'd0, pht_wdata}, 32'd2);
        chk("stalled_not_counted", c_total, 32'd6);
        next(); set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0); #1;
        chk("drain3_waddr", {26'd0, pht_waddr}, 32'd3);
        chk("drain3_wdata", {30'd0, pht_wdata}, 32'd3);
        next(); #1;
        chk("drain4_waddr", {26'd0, pht_waddr}, 32'd4);
        chk("drain4_wdata", {30'd0, pht_wdata}, 32'd0);
        next(); #1;
        chk("drain5_we", {31'd0, pht_we}, 32'd1);
        chk("drain5_waddr", {26'd0, pht_waddr}, 32'd5);
        chk("drain5_wdata", {30'd0, pht_wdata}, 32'd1);
        next(); #1;
        chk("drained_we", {31'd0, pht_we}, 32'd0);
        chk("drained_c_total", c_total, 32'd7);
        chk("drained_c_correct", c_correct, 32'd6);

        // back-to-back mispredicts; first wraps pc+4 to zero
        set_ex(1'b1, 32'hFFFF_FFFC, 32'hDEAD_0000, 1'b0, 1'b1, 2'd2);
        next(); set_ex(1'b1, 32'h0000_0200, 32'h0000_1234, 1'b1, 1'b0, 2'd3); #1;
        chk("wrap_redirect", {31'd0, redirect}, 32'd1);
        chk("wrap_redirect_pc", redirect_pc, 32'h0000_0000);
        chk("wrap_waddr", {26'd0, pht_waddr}, 32'd63);
        chk("wrap_wdata", {30'd0, pht_wdata}, 32'd1);
        next(); set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0); #1;
        chk("b2b_redirect", {31'd0, redirect}, 32'd1);
        chk("b2b_redirect_pc", redirect_pc, 32'h0000_1234);
        chk("b2b_no_enqueue", {31'd0, pht_we}, 32'd0);
        next(); #1;
        chk("b2b_end", {31'd0, redirect}, 32'd0);
        chk("b2b_c_total", c_total, 32'd9);
        chk("b2b_c_correct", c_correct, 32'd6);

        // three queued updates, then reset together with a mispredict
        if_rd_req = 1'b1;
        set_ex(1'b1, 32'h0000_0300, 32'h0, 1'b1, 1'b1, 2'd0);
        next(); set_ex(1'b1, 32'h0000_0304, 32'h0, 1'b1, 1'b1, 2'd1);
        next(); set_ex(1'b1, 32'h0000_0308, 32'h0, 1'b1, 1'b1, 2'd2);
        next(); #1;
        chk("q3_stall", {31'd0, stall_ex}, 32'd0);
        set_ex(1'b1, 32'h0000_030C, 32'h0000_0400, 1'b0, 1'b1, 2'd1);
        rst = 1'b1;
        next(); set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0); #1;
        chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_ex}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        chk("mid_rst_c_total", c_total, 32'd0);
        chk("mid_rst_waddr", {26'd0, pht_waddr}, 32'd0);
        chk("mid_rst_wdata", {30'd0, pht_wdata}, 32'd1);
        rst = 1'b0;
        next(); #1;
        chk("reinit_we", {31'd0, pht_we}, 32'd1);
        chk("reinit_waddr", {26'd0, pht_waddr}, 32'd1);
        chk("reinit_ready", {31'd0, ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
